// File: rtl/posit_round_encode.sv
// posit_round_encode: two-stage rounder/encoder for posit<N,1>.
// Takes the decoded sum from the adder core (sign, scale factor, two's
// complement fraction, guard, sticky, nonzero flag) and produces the final
// N-bit posit with round-to-nearest-even and saturation. Both stages sit
// behind a valid/ready handshake, so back-pressure stalls the pipeline
// without losing or duplicating items.
module posit_round_encode #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             i_s,
    input  logic [N-10:0]    i_sf,
    input  logic [N-5:0]     i_mant,
    input  logic             i_guard,
    input  logic             i_sticky,
    input  logic             i_nzn,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [N-1:0]     o_posit,
    output logic             o_inexact
);

    localparam int SFW = N - 9;     // scale factor width
    localparam int FW  = N - 4;     // fraction width
    localparam int KW  = SFW - 1;   // regime value width
    localparam int TW  = FW + 3;    // exponent + fraction + guard + sticky
    localparam int SW  = 3 * N;     // assembly string, wide enough for any regime

    localparam logic signed [KW-1:0] KK_HI = KW'(N - 2);
    localparam logic signed [KW-1:0] KK_LO = -KK_HI;

    // Left-aligned regime run: positive regime is a run of ones closed by a
    // zero, negative regime is a run of zeros closed by a one. The shift
    // amount is the run length minus one in both cases.
    function automatic logic [N-1:0] regime_bits(input logic neg, input logic [KW-1:0] sh);
        logic [N-1:0] pat;
        if (neg) begin
            pat = {1'b1, {(N-1){1'b0}}} >> sh;
        end else begin
            pat = ~({N{1'b1}} >> sh);
        end
        return pat;
    endfunction

    // ---------------- handshake ----------------
    logic rdy_r;
    logic s1_valid_r;
    logic s2_valid_r;
    logic s1_load_s;
    logic s2_load_s;

    assign s2_load_s = !s2_valid_r | o_ready;
    assign s1_load_s = !s1_valid_r | s2_load_s;
    assign in_ready  = rdy_r & s1_load_s;

    // Input acceptance is held off until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_r <= 1'b0;
        end else begin
            rdy_r <= 1'b1;
        end
    end

    // ---------------- stage 1: assemble ----------------
    logic signed [KW-1:0] k_s;
    logic signed [KW-1:0] kk_s;
    logic                 e_s;
    logic [KW-1:0]        rlen_s;
    logic [N-1:0]         regime_s;
    logic [TW-1:0]        tail_s;
    logic [SW-1:0]        str_s;
    logic [N-2:0]         kept_s;
    logic                 rbit_s;
    logic                 sbit_s;
    logic                 max_s;
    logic                 min_s;

    // Build {regime, e, fraction, guard, sticky} and split it at N-1 bits
    always_comb begin
        k_s      = i_sf[SFW-1:1];
        kk_s     = i_s ? ~k_s : k_s;
        e_s      = i_sf[0] ^ i_s;
        rlen_s   = kk_s[KW-1] ? (KW'(1) - kk_s) : (kk_s + KW'(2));
        regime_s = regime_bits(kk_s[KW-1], rlen_s - KW'(1));
        tail_s   = {e_s, i_mant, i_guard, i_sticky};
        str_s    = {regime_s, {(SW-N){1'b0}}} | ({tail_s, {(SW-TW){1'b0}}} >> rlen_s);
        kept_s   = str_s[SW-1 -: N-1];
        rbit_s   = str_s[SW-N];
        sbit_s   = |str_s[SW-N-1:0];
        max_s    = (kk_s >= KK_HI);
        min_s    = (kk_s < KK_LO);
    end

    logic         s1_sign_r;
    logic [N-2:0] s1_kept_r;
    logic         s1_rbit_r;
    logic         s1_sbit_r;
    logic         s1_nzn_r;
    logic         s1_max_r;
    logic         s1_min_r;

    // Stage 1 register: advances whenever it is empty or stage 2 takes its item
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_kept_r  <= {(N-1){1'b0}};
            s1_rbit_r  <= 1'b0;
            s1_sbit_r  <= 1'b0;
            s1_nzn_r   <= 1'b0;
            s1_max_r   <= 1'b0;
            s1_min_r   <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= in_valid & rdy_r;
            end
            if (in_valid & in_ready) begin
                s1_sign_r <= i_s;
                s1_kept_r <= kept_s;
                s1_rbit_r <= rbit_s;
                s1_sbit_r <= sbit_s;
                s1_nzn_r  <= i_nzn;
                s1_max_r  <= max_s;
                s1_min_r  <= min_s;
            end
        end
    end

    // ---------------- stage 2: round and saturate ----------------
    logic         inc_s;
    logic [N-1:0] sum_s;
    logic [N-1:0] posit_s;
    logic         inexact_s;

    // Round to nearest even, then keep the result inside the valid code range
    always_comb begin
        inc_s = s1_rbit_r & (s1_kept_r[0] | s1_sbit_r);
        sum_s = {1'b0, s1_kept_r} + {{(N-1){1'b0}}, inc_s};
        if (!s1_nzn_r) begin
            // zero or NaR pass straight through, always exact
            posit_s   = s1_sign_r ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};
            inexact_s = 1'b0;
        end else if (s1_max_r) begin
            // regime run of ones too long: body saturates to all ones
            posit_s   = {s1_sign_r, {(N-1){1'b1}}};
            inexact_s = 1'b1;
        end else if (s1_min_r) begin
            // regime run of zeros too long: body saturates to 0..01
            posit_s   = {s1_sign_r, {(N-2){1'b0}}, 1'b1};
            inexact_s = 1'b1;
        end else if (sum_s[N-1]) begin
            // increment would spill into the sign bit
            posit_s   = {s1_sign_r, {(N-1){1'b1}}};
            inexact_s = s1_rbit_r | s1_sbit_r;
        end else if (sum_s[N-2:0] == {(N-1){1'b0}}) begin
            // an all-zero body would read as zero or NaR
            posit_s   = {s1_sign_r, {(N-2){1'b0}}, 1'b1};
            inexact_s = s1_rbit_r | s1_sbit_r;
        end else begin
            posit_s   = {s1_sign_r, sum_s[N-2:0]};
            inexact_s = s1_rbit_r | s1_sbit_r;
        end
    end

    logic [N-1:0] s2_posit_r;
    logic         s2_inexact_r;

    // Stage 2 register: output holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_posit_r   <= {N{1'b0}};
            s2_inexact_r <= 1'b0;
        end else begin
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (s2_load_s && s1_valid_r) begin
                s2_posit_r   <= posit_s;
                s2_inexact_r <= inexact_s;
            end
        end
    end

    assign o_valid   = s2_valid_r;
    assign o_posit   = s2_posit_r;
    assign o_inexact = s2_inexact_r;

endmodule
